// File: rtl/ifetch_queue_pkg.sv
// rtl/ifetch_queue_pkg.sv - shared types and constants for the instruction-fetch queue
// Purpose: widths, reset PC default, NOP encoding and the queued {pc, instr} entry type.
// Ports: none (package).
package ifetch_queue_pkg;

  localparam int          INSTR_W      = 32;
  localparam int          ADDR_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam logic [31:0] NOP          = 32'h0;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - synchronous FIFO with push/pop/flush for fetched instructions
// Purpose: DEPTH-entry storage of W-bit words; flush clears pointers and count.
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   push, pop   write wdata at tail / retire head (push on full only with pop)
//   flush       discard all entries; wins over push and pop
//   wdata       data written on push
//   count       number of valid entries (0..DEPTH)
//   full        count == DEPTH
//   head        oldest entry, zero when empty
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [W-1:0]             head
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      // push and pop together leave the occupancy unchanged, even when full
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign full  = (count_q == FULL_CNT);
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction-fetch front end: PC, ROM addressing, fetch FIFO
// Purpose: owns the PC, addresses a zero-latency instruction ROM, queues {pc, instr}
//          pairs for decode and flushes on execute redirects.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   imem_addr / imem_rdata        ROM word address (pc[AW+1:2]) / same-cycle instruction
//   redirect_valid / redirect_pc  flush queue and load new word-aligned PC
//   out_valid / out_ready         decode handshake for the queue head
//   out_instr / out_pc            head instruction and its PC (zero when empty)
//   fetch_count                   instructions pushed since reset, wrapping
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [31:0]   fetch_count
);

  logic [31:0]            pc_q, pc_d;
  logic [31:0]            fetch_count_q, fetch_count_d;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   pop, push;
  ifq_entry_t             wr_entry;
  ifq_entry_t             head_entry;

  assign out_valid = (fifo_count != '0);

  // A redirect suppresses both sides: the presented head is not consumed.
  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = ~redirect_valid & (~fifo_full | pop);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = imem_rdata;

  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc_d          = pc_q + 32'd4;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .head  (head_entry)
  );

  // ROM aliasing every 2^AW words is intended.
  assign imem_addr   = pc_q[AW+1:2];
  assign out_pc      = head_entry.pc;
  assign out_instr   = head_entry.instr;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue with a {pc, instr} scoreboard
module tb_ifetch_queue;

  logic        clk;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb[$];
  logic [31:0] mpc;
  logic [31:0] mfc;

  ifetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_count    (fetch_count)
  );

  // ROM[i] = i + 100
  assign imem_rdata = 32'(imem_addr) + 32'd100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic do_pop, do_push;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    check("imem_addr", 32'(imem_addr), 32'(mpc[9:2]));
    check("fetch_count", fetch_count, mfc);
    if (sb.size() != 0) begin
      check("out_pc", out_pc, sb[0][63:32]);
      check("out_instr", out_instr, sb[0][31:0]);
    end else begin
      check("empty_pc", out_pc, 32'h0);
      check("empty_instr", out_instr, 32'h0);
    end
    do_pop  = (sb.size() != 0) && out_ready && !redirect_valid;
    do_push = !redirect_valid && ((sb.size() < 4) || do_pop);
    @(posedge clk);
    if (redirect_valid) begin
      sb.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back({mpc, 32'(mpc[9:2]) + 32'd100});
        mpc = mpc + 32'd4;
        mfc = mfc + 32'd1;
      end
    end
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Reset asserted away from the clock edge so its asynchronous effect is visible.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_fcnt", fetch_count, 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    sb.delete();
    mpc = 32'h0;
    mfc = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    mpc            = 32'h0;
    mfc            = 32'h0;
    #1;

    // 1: streaming at one instruction per cycle
    do_reset();
    out_ready = 1'b1;
    cycles(10);

    // 2/3: stall until full, then drain with simultaneous push+pop
    do_reset();
    out_ready = 1'b0;
    cycles(10);
    check("sat_addr", 32'(imem_addr), 32'h4);
    check("sat_fcnt", fetch_count, 32'h4);
    check("sat_head", out_pc, 32'h0);
    out_ready = 1'b1;
    cycles(8);

    // 4: redirect to 0x43 with 3 queued and decode ready
    do_reset();
    out_ready = 1'b0;
    cycles(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    out_ready      = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    check("redir_valid", 32'(out_valid), 32'h0);
    check("redir_addr", 32'(imem_addr), 32'h10);
    cycle();
    check("redir_pc", out_pc, 32'h40);
    check("redir_instr", out_instr, 32'd116);
    cycles(3);

    // 5: PC and ROM address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3FC;
    cycle();
    redirect_valid = 1'b0;
    check("wrap_addr_hi", 32'(imem_addr), 32'd255);
    cycle();
    check("wrap_addr_lo", 32'(imem_addr), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    check("wrap_pc_head", out_pc, 32'hFFFF_FFFC);
    check("wrap_pc_addr", 32'(imem_addr), 32'd0);
    cycles(4);

    // 6: asynchronous reset with two entries queued
    do_reset();
    out_ready = 1'b0;
    cycles(2);
    check("pre_rst_fcnt", fetch_count, 32'h2);
    do_reset();
    out_ready = 1'b1;
    cycles(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
